// File: rtl/riot_timer_irq_if.sv
// CPU-side register bus for the 6532 timer/interrupt front end.
// Master drives strobes and write data; slave returns read data.
interface riot_timer_irq_if;
  logic       CS;
  logic       RW;
  logic [4:0] A;
  logic [7:0] DIN;
  logic [7:0] DOUT;

  modport master (
    output CS, RW, A, DIN,
    input  DOUT
  );

  modport slave (
    input  CS, RW, A, DIN,
    output DOUT
  );
endinterface

// File: rtl/riot_timer_irq.sv
// 6532 interval timer bus decode, underflow/PA7 flags and IRQ.
// Load strobe is combinational; flags, read data and IRQ_N are registered.
module riot_timer_irq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RES,
  riot_timer_irq_if.slave bus,
  input  logic [7:0]      TIM_CNT,
  input  logic            PA7,
  output logic            TIM_WE,
  output logic [1:0]      TIM_MODE,
  output logic [7:0]      TIM_IN,
  output logic            IRQ_N
);

  logic                   tflag, pflag;
  logic                   tie, pie, pedge;
  logic [7:0]             prev_cnt;
  logic                   we_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  logic tflag_n, pflag_n;
  logic tie_n, pie_n, pedge_n;
  logic tw, ec, tr, fr;
  logic uf, pa_edge, sync;

  assign tw = bus.CS & ~bus.RW & bus.A[4] & bus.A[2];
  assign ec = bus.CS & ~bus.RW & bus.A[4] & ~bus.A[2];
  assign tr = bus.CS & bus.RW & bus.A[2] & ~bus.A[0];
  assign fr = bus.CS & bus.RW & bus.A[2] & bus.A[0];

  assign TIM_WE   = tw & ~RES;
  assign TIM_MODE = tw ? bus.A[1:0] : 2'b00;
  assign TIM_IN   = tw ? bus.DIN : 8'h00;

  // we_d masks the wrap that a fresh load of FF would otherwise fake
  assign uf = (prev_cnt == 8'h00) && (TIM_CNT == 8'hFF) && !we_d;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign pa_edge = (sync != hist) && (sync == pedge);

  // Flag/enable next state; set beats a same-cycle clear
  always_comb begin
    tflag_n = uf | (tflag & ~(tw | tr));
    pflag_n = pa_edge | (pflag & ~fr);
    tie_n   = tie;
    pie_n   = pie;
    pedge_n = pedge;
    if (tw || tr) tie_n = bus.A[3];
    if (ec) begin
      pie_n   = bus.A[1];
      pedge_n = bus.A[0];
    end
  end

  // State, read data and IRQ register
  always_ff @(posedge CLK) begin
    if (RES) begin
      tflag    <= 1'b0;
      pflag    <= 1'b0;
      tie      <= 1'b0;
      pie      <= 1'b0;
      pedge    <= 1'b0;
      bus.DOUT <= 8'h00;
      IRQ_N    <= 1'b1;
      prev_cnt <= 8'h00;
      we_d     <= 1'b1;
      sync_q   <= '0;
      hist     <= 1'b0;
    end else begin
      tflag    <= tflag_n;
      pflag    <= pflag_n;
      tie      <= tie_n;
      pie      <= pie_n;
      pedge    <= pedge_n;
      IRQ_N    <= ~((tflag_n & tie_n) | (pflag_n & pie_n));
      prev_cnt <= TIM_CNT;
      we_d     <= TIM_WE;
      sync_q[0] <= PA7;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist <= sync;
      if (tr)
        bus.DOUT <= TIM_CNT;
      else if (fr)
        bus.DOUT <= {tflag, pflag, 6'b0};
    end
  end

endmodule

// File: tb/tb_riot_timer_irq.sv
// Directed self-checking bench for riot_timer_irq.
// Inputs change 1ns after each rising edge; checks follow 1ns later.
module tb_riot_timer_irq;
  logic       CLK = 1'b0;
  logic       RES;
  logic [7:0] TIM_CNT;
  logic       PA7;
  logic       TIM_WE;
  logic [1:0] TIM_MODE;
  logic [7:0] TIM_IN;
  logic       IRQ_N;
  int         checks = 0;
  int         errors = 0;

  riot_timer_irq_if bus ();

  riot_timer_irq #(.SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RES      (RES),
    .bus      (bus.slave),
    .TIM_CNT  (TIM_CNT),
    .PA7      (PA7),
    .TIM_WE   (TIM_WE),
    .TIM_MODE (TIM_MODE),
    .TIM_IN   (TIM_IN),
    .IRQ_N    (IRQ_N)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic rw, input logic [4:0] a,
                     input logic [7:0] d);
    bus.CS  = 1'b1;
    bus.RW  = rw;
    bus.A   = a;
    bus.DIN = d;
  endtask

  task automatic idle();
    bus.CS  = 1'b0;
    bus.RW  = 1'b1;
    bus.A   = 5'h00;
    bus.DIN = 8'h00;
  endtask

  initial begin
    idle();
    RES = 1'b1;
    TIM_CNT = 8'h10;
    PA7 = 1'b0;
    step();
    step();
    chk("rst_dout", bus.DOUT, 8'h00);
    chk("rst_irq", {7'b0, IRQ_N}, 8'h01);
    RES = 1'b0;
    step();

    acc(1'b0, 5'b11101, 8'h03);
    settle();
    chk("t1_we", {7'b0, TIM_WE}, 8'h01);
    chk("t1_mode", {6'b0, TIM_MODE}, 8'h01);
    chk("t1_in", TIM_IN, 8'h03);
    step();
    idle();
    TIM_CNT = 8'h03;
    settle();
    chk("t1_we_off", {7'b0, TIM_WE}, 8'h00);
    chk("t1_mode_off", {6'b0, TIM_MODE}, 8'h00);
    chk("t1_irq", {7'b0, IRQ_N}, 8'h01);

    TIM_CNT = 8'h01;
    step();
    TIM_CNT = 8'h00;
    step();
    chk("t2_pre_irq", {7'b0, IRQ_N}, 8'h01);
    TIM_CNT = 8'hFF;
    step();
    chk("t2_uf_irq", {7'b0, IRQ_N}, 8'h00);
    acc(1'b1, 5'b00100, 8'h00);
    step();
    idle();
    settle();
    chk("t2_rd_dout", bus.DOUT, 8'hFF);
    chk("t2_rd_irq", {7'b0, IRQ_N}, 8'h01);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t2_flags", bus.DOUT, 8'h00);

    TIM_CNT = 8'h00;
    step();
    acc(1'b0, 5'b11100, 8'hFF);
    step();
    idle();
    TIM_CNT = 8'hFF;
    step();
    chk("t3_irq", {7'b0, IRQ_N}, 8'h01);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t3_flags", bus.DOUT, 8'h00);

    acc(1'b0, 5'b10011, 8'h00);
    step();
    idle();
    PA7 = 1'b1;
    step();
    chk("t4_sync1", {7'b0, IRQ_N}, 8'h01);
    step();
    chk("t4_sync2", {7'b0, IRQ_N}, 8'h01);
    step();
    chk("t4_pirq", {7'b0, IRQ_N}, 8'h00);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t4_flags", bus.DOUT, 8'h40);
    chk("t4_clr_irq", {7'b0, IRQ_N}, 8'h01);
    PA7 = 1'b0;
    repeat (4) step();
    chk("t4_fall_irq", {7'b0, IRQ_N}, 8'h01);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t4_fall_flags", bus.DOUT, 8'h00);

    TIM_CNT = 8'h00;
    step();
    TIM_CNT = 8'hFF;
    acc(1'b1, 5'b01100, 8'h00);
    step();
    idle();
    chk("t5_uf_rd_dout", bus.DOUT, 8'hFF);
    chk("t5_uf_rd_irq", {7'b0, IRQ_N}, 8'h00);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t5_tflag", bus.DOUT, 8'h80);
    chk("t5_tflag_irq", {7'b0, IRQ_N}, 8'h00);

    PA7 = 1'b1;
    step();
    step();
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t5_edge_rd", bus.DOUT, 8'h80);
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t5_edge_kept", bus.DOUT, 8'hC0);

    PA7 = 1'b0;
    repeat (4) step();
    PA7 = 1'b1;
    repeat (3) step();
    chk("t6_pre_irq", {7'b0, IRQ_N}, 8'h00);
    RES = 1'b1;
    acc(1'b0, 5'b11101, 8'h55);
    settle();
    chk("t6_we_rst", {7'b0, TIM_WE}, 8'h00);
    step();
    chk("t6_irq", {7'b0, IRQ_N}, 8'h01);
    chk("t6_dout", bus.DOUT, 8'h00);
    RES = 1'b0;
    idle();
    step();
    acc(1'b1, 5'b00101, 8'h00);
    step();
    idle();
    chk("t6_flags", bus.DOUT, 8'h00);
    chk("t6_irq_post", {7'b0, IRQ_N}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riot_timer_irq.md
Name: riot_timer_irq

Overview:
- Bus-side front end and interrupt logic for the 6532 interval timer.
- Decodes CPU register strobes into timer load commands (write enable, prescale mode, initial value).
- Watches the timer count for underflow, detects PA7 edges, and holds the two interrupt flags.
- Drives IRQ_N and returns read data for the timer and interrupt-flag registers.

Parameters:
- SYNC_STAGES, 2, number of flip-flops synchronising PA7 before edge detection; legal range 1..3.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RES  in  1  synchronous reset, active high.
- CS  in  1  single-cycle access strobe, already qualified as chip selected with RAM deselected.
- RW  in  1  1 = read, 0 = write; sampled only when CS=1.
- A  in  5  register address; sampled only when CS=1.
- DIN  in  8  write data.
- TIM_CNT  in  8  current timer count from the interval timer.
- PA7  in  1  asynchronous edge-interrupt pin.
- TIM_WE  out  1  timer load strobe, one cycle wide.
- TIM_MODE  out  2  prescale select: 00=1T, 01=8T, 10=64T, 11=1024T.
- TIM_IN  out  8  timer load value.
- DOUT  out  8  registered read data.
- IRQ_N  out  1  interrupt request, active low, registered.

Behaviour:
Access decode (only when CS=1):
- Timer write (RW=0, A[4]=1, A[2]=1):
  - Same cycle: TIM_WE=1, TIM_MODE=A[1:0], TIM_IN=DIN. These outputs are combinational from the strobe.
  - Next edge: TIE <= A[3]; TFLAG cleared.
- Edge-control write (RW=0, A[4]=1, A[2]=0): next edge PIE <= A[1], PEDGE <= A[0] (0 = falling, 1 = rising).
- Timer read (RW=1, A[2]=1, A[0]=0): next edge DOUT <= TIM_CNT, TIE <= A[3], TFLAG cleared.
- Flag read (RW=1, A[2]=1, A[0]=1): next edge DOUT <= {TFLAG, PFLAG, 6'b0}, PFLAG cleared. TFLAG is unaffected.
- Any other access: no state change; DOUT holds.
- When CS=0: TIM_WE=0, and TIM_MODE/TIM_IN are 0.

Underflow detection:
- Registers prev_cnt <= TIM_CNT and we_d <= TIM_WE every cycle.
- Underflow = (prev_cnt==8'h00) && (TIM_CNT==8'hFF) && !we_d.
- A load of 8'hFF immediately after a count of 0 is therefore not an underflow.
- Underflow sets TFLAG at the next edge.
- Set has priority over a same-cycle clear from a timer read or write.

PA7 path:
- SYNC_STAGES flip-flop chain, then one history flop.
- Edge = (sync != hist) and the new level matches PEDGE.
- Edge sets PFLAG at the next edge, regardless of PIE.
- Set has priority over a same-cycle flag-read clear.
- Changing PEDGE does not itself generate an edge.

IRQ:
- IRQ_N <= !((TFLAG & TIE) | (PFLAG & PIE)), computed from next-state values, so IRQ_N falls on the same edge the flag sets.

Reset (RES=1, synchronous):
- TFLAG=0, PFLAG=0, TIE=0, PIE=0, PEDGE=0, DOUT=8'h00, IRQ_N=1.
- Synchroniser and history flops load 0. prev_cnt=8'h00, we_d=1, which suppresses a false underflow on the first cycle after reset.
- Reset mid-access discards the access. TIM_WE is forced 0 while RES=1.

Width rules: all comparisons are exact 8-bit; no arithmetic on TIM_CNT.

Test Plan:
1. Reset, then write A=5'b11101 (A[3]=1, mode 01), DIN=8'h03 → TIM_WE=1 for exactly 1 cycle with TIM_MODE=01, TIM_IN=8'h03; TIE=1; IRQ_N stays 1.
2. Drive TIM_CNT 8'h01→8'h00→8'hFF with no load → TFLAG=1 and IRQ_N=0 on the edge after 8'hFF appears. Then timer read A=5'b00100 → DOUT=TIM_CNT, TFLAG=0, IRQ_N=1 (A[3]=0 also clears TIE).
3. TIM_CNT=8'h00, then write DIN=8'hFF, so TIM_CNT becomes 8'hFF next cycle → TFLAG stays 0, no IRQ.
4. Edge-control write A=5'b10011 (PIE=1, rising). Toggle PA7 0→1 → PFLAG=1 after SYNC_STAGES+1 edges and IRQ_N=0. Flag read A=5'b00101 → DOUT=8'h40; PFLAG cleared; IRQ_N=1. A falling edge afterwards sets nothing.
5. Underflow coincident with a timer read → TFLAG remains 1 (set wins). PA7 edge coincident with a flag read → DOUT shows the old PFLAG, and PFLAG=1 afterwards.
6. Assert RES with TFLAG=PFLAG=1 and IRQ_N=0 → next edge all flags 0, IRQ_N=1, DOUT=8'h00. A CS write issued during RES produces TIM_WE=0.
